tl_ul_mem_responder: RTL and testbench
======================================

# tl_ul_mem_responder

- Single-beat TileLink-UL manager (slave) memory model.
- Accepts Get, PutFullData and PutPartialData on channel A and returns AccessAckData or AccessAck on channel D.
- Sits at the far end of the L1 adapter / crossbar path and answers transactions issued by the initiator side.
- Holds one outstanding transaction at a time; backed by an internal register array.

## Interface
Widths come from `tl_pkg.vh` (`TL_ADDR_BITS`, `TL_SIZE_BITS`, `TL_SOURCE_BITS`, `TL_DATA_BYTES`, with `TL_DATA_BYTES` = 8).

Parameters:
- MEM_DEPTH_WORDS, 256, number of `TL_DATA_BYTES`-wide words.
- BASE_ADDR, 32'h0, byte address of word 0.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  channel A request valid.
- a_ready  out  1  channel A ready.
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- a_param  in  3  ignored.
- a_size  in  `TL_SIZE_BITS`  log2 bytes.
- a_source  in  `TL_SOURCE_BITS`  requester ID.
- a_address  in  `TL_ADDR_BITS`  byte address.
- a_mask  in  `TL_DATA_BYTES`  byte lanes.
- a_data  in  `TL_DATA_BYTES`*8  write data.
- d_valid  out  1  channel D response valid.
- d_ready  in  1  channel D ready.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  `TL_SIZE_BITS`  echo of a_size.
- d_source  out  `TL_SOURCE_BITS`  echo of a_source.
- d_denied  out  1  request rejected.
- d_data  out  `TL_DATA_BYTES`*8  read data.
- d_corrupt  out  1  data invalid.

## Operation
States:
- IDLE: a_ready=1, d_valid=0.
  - On a_valid&a_ready, capture opcode, size, source, address, mask and data; perform the access; go to RESP.
- RESP: a_ready=0, d_valid=1, all d_* fields held stable.
  - On d_valid&d_ready, go to IDLE.

Addressing:
- Word index = (a_address − BASE_ADDR) >> log2(`TL_DATA_BYTES`), truncated to clog2(MEM_DEPTH_WORDS) bits.
- Address bits below the word size are ignored for word selection.

Opcode behaviour:
- Get: d_opcode=1; d_data = full word at index, independent of a_size and a_mask.
- PutFullData and PutPartialData: write byte i of a_data where a_mask[i]=1; other bytes unchanged; d_opcode=0, d_data=0.
- Unsupported opcode (2, 3, 5, 6, 7): d_opcode=0, no write.

Reset:
- Memory contents are not cleared by rst and are undefined at power-up.
- Reset mid-operation (RESP with d_ready=0) drops the pending response.
- A write already performed in that transaction stays in memory.

## Timing
- Reset values: a_ready=0 during rst, 1 the first cycle after; d_valid=0; d_opcode=0; d_param=0; d_size=0; d_source=0; d_denied=0; d_data=0; d_corrupt=0.
- Handshake on edge N → d_valid=1 from cycle N+1. Minimum request-to-response latency is 1 cycle.
- Memory write takes effect at edge N, so a Get accepted at a later edge observes it.
- Response completes at the first edge with d_ready=1 while in RESP; a_ready returns to 1 the cycle after that edge.
- Maximum throughput: one transaction per 2 cycles.
- d_* must not change while d_valid=1 and d_ready=0.
- a_valid held while a_ready=0 is ignored until IDLE.

## Configuration
`TL_MEM_DENY_EN` defined:
- Denied conditions: a_size > log2(`TL_DATA_BYTES`); a_address not aligned to 2^a_size; a_address < BASE_ADDR; a_address ≥ BASE_ADDR + MEM_DEPTH_WORDS*`TL_DATA_BYTES`; unsupported opcode.
- Any denied condition → d_denied=1 and no memory write.
- Denied Get additionally returns d_data=0 and d_corrupt=1.

`TL_MEM_DENY_EN` undefined:
- No checks.
- Out-of-range addresses alias by index truncation.
- d_denied=0 and d_corrupt=0 always.

## Test plan
1. PutFullData at 0x0, size 3, mask 0xFF, data 64'hABCD_1234_5678_9ABC, source 2 → AccessAck with d_source=2, d_denied=0. Then Get at 0x0 → d_opcode=1, d_data=64'hABCD_1234_5678_9ABC, d_valid one cycle after the handshake.
2. After scenario 1, PutPartialData at 0x0, mask 0x0F, data 64'h0000_0000_1111_2222 → AccessAck. Get at 0x0 → 64'hABCD_1234_1111_2222.
3. Get with d_ready=0 for 5 cycles → d_valid and d_* stable for 5 cycles, a_ready=0 throughout. d_ready=1 → a_ready=1 the next cycle.
4. With `TL_MEM_DENY_EN`, Get at BASE_ADDR + MEM_DEPTH_WORDS*8 → d_denied=1, d_corrupt=1, d_data=0. Without the macro, the same Get returns word 0.
5. Put at 0x8, then rst asserted during RESP with d_ready=0 → d_valid=0 the cycle after the reset edge, a_ready=1 after rst deasserts. Get at 0x8 → written data retained.
6. Back-to-back Gets with a_valid held high and d_ready=1, sources 0–3 → four responses in order, each d_source matching its request, one response every 2 cycles.

Source files
------------

// File: rtl/tl_ul_mem_responder.sv
// tl_ul_mem_responder: single-beat TileLink-UL manager backed by a register array.
// Define TL_MEM_DENY_EN to reject bad size/alignment/range/opcode with d_denied/d_corrupt.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tl_ul_mem_responder #(
  parameter int unsigned                MEM_DEPTH_WORDS = 256,
  parameter logic [`TL_ADDR_BITS-1:0]   BASE_ADDR       = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [2:0]                    a_opcode,
  input  logic [2:0]                    a_param,
  input  logic [`TL_SIZE_BITS-1:0]      a_size,
  input  logic [`TL_SOURCE_BITS-1:0]    a_source,
  input  logic [`TL_ADDR_BITS-1:0]      a_address,
  input  logic [`TL_DATA_BYTES-1:0]     a_mask,
  input  logic [`TL_DATA_BYTES*8-1:0]   a_data,
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic [2:0]                    d_opcode,
  output logic [1:0]                    d_param,
  output logic [`TL_SIZE_BITS-1:0]      d_size,
  output logic [`TL_SOURCE_BITS-1:0]    d_source,
  output logic                          d_denied,
  output logic [`TL_DATA_BYTES*8-1:0]   d_data,
  output logic                          d_corrupt
);

  localparam int unsigned AW     = `TL_ADDR_BITS;
  localparam int unsigned SW     = `TL_SIZE_BITS;
  localparam int unsigned BYTES  = `TL_DATA_BYTES;
  localparam int unsigned DATA_W = BYTES * 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned IDX_W  = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {
    OP_PUT_FULL    = 3'd0,
    OP_PUT_PARTIAL = 3'd1,
    OP_GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    OP_ACCESS_ACK      = 3'd0,
    OP_ACCESS_ACK_DATA = 3'd1
  } d_op_e;

  typedef enum logic {IDLE, RESP} state_e;

  state_e              state, state_next;
  logic [DATA_W-1:0]   mem [MEM_DEPTH_WORDS];
  logic [AW-1:0]       offset;
  logic [IDX_W-1:0]    idx;
  logic                hs;
  logic                is_get;
  logic                is_put;
  logic                denied;
  logic                do_write;
  logic                unused_bits;

  // Gating with rst keeps a_ready low for the whole reset window, not just after it.
  assign a_ready  = (state == IDLE) && !rst;
  assign d_valid  = (state == RESP);
  assign d_param  = '0;
  assign hs       = a_valid && a_ready;
  assign is_get   = (a_opcode == OP_GET);
  assign is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
  assign offset   = a_address - BASE_ADDR;
  assign idx      = offset[OFF_W +: IDX_W];
  assign do_write = hs && is_put && !denied;

`ifdef TL_MEM_DENY_EN
  localparam logic [63:0]   MEM_LIMIT = 64'(BASE_ADDR) + 64'(MEM_DEPTH_WORDS) * 64'(BYTES);
  localparam logic [SW-1:0] MAX_SIZE  = SW'(OFF_W);
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] align_mask;

  assign align_mask = (ADDR_ONE << a_size) - ADDR_ONE;
  assign denied     = (a_size > MAX_SIZE)
                   || ((a_address & align_mask) != '0)
                   || (a_address < BASE_ADDR)
                   || (64'(a_address) >= MEM_LIMIT)
                   || !(is_get || is_put);
`else
  // Without checking, out-of-range addresses simply alias through idx truncation.
  assign denied = 1'b0;
`endif

  assign unused_bits = ^{a_param, offset};

  // NOTE: the array has no reset; contents survive rst and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next state gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs)      state_next = RESP;
      RESP:    if (d_ready) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // Response fields load only on the handshake, so they stay stable throughout RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_opcode  <= '0;
      d_size    <= '0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_data    <= '0;
      d_corrupt <= 1'b0;
    end else if (hs) begin
      d_opcode  <= is_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= denied;
      d_data    <= (is_get && !denied) ? mem[idx] : '0;
      d_corrupt <= is_get && denied;
    end
  end

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Self-checking bench for tl_ul_mem_responder: table-driven transactions through a scoreboard
// plus hand-written backpressure, mid-transaction reset and back-to-back sequences.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tb_tl_ul_mem_responder;

  localparam int AW   = `TL_ADDR_BITS;
  localparam int SW   = `TL_SIZE_BITS;
  localparam int SRCW = `TL_SOURCE_BITS;
`ifdef TL_MEM_DENY_EN
  localparam bit DENY = 1'b1;
`else
  localparam bit DENY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid;
  logic            a_ready;
  logic [2:0]      a_opcode;
  logic [2:0]      a_param;
  logic [SW-1:0]   a_size;
  logic [SRCW-1:0] a_source;
  logic [AW-1:0]   a_address;
  logic [7:0]      a_mask;
  logic [63:0]     a_data;
  logic            d_valid;
  logic            d_ready;
  logic [2:0]      d_opcode;
  logic [1:0]      d_param;
  logic [SW-1:0]   d_size;
  logic [SRCW-1:0] d_source;
  logic            d_denied;
  logic [63:0]     d_data;
  logic            d_corrupt;

  tl_ul_mem_responder #(.MEM_DEPTH_WORDS(256), .BASE_ADDR('0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
    .d_corrupt(d_corrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      op;
    logic [SW-1:0]   size;
    logic [SRCW-1:0] src;
    logic [AW-1:0]   addr;
    logic [7:0]      mask;
    logic [63:0]     data;
    logic [2:0]      exp_op;
    logic [63:0]     exp_data;
    logic            exp_denied;
    logic            exp_corrupt;
  } vec_t;

  vec_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             pass_cnt++;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [SW-1:0] size,
                              input logic [SRCW-1:0] src, input logic [AW-1:0] addr,
                              input logic [7:0] mask, input logic [63:0] data,
                              input logic [2:0] exp_op, input logic [63:0] exp_data,
                              input logic exp_denied, input logic exp_corrupt);
    vec_t v;
    v.op = op; v.size = size; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
    v.exp_op = exp_op; v.exp_data = exp_data;
    v.exp_denied = exp_denied; v.exp_corrupt = exp_corrupt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a_opcode = v.op; a_size = v.size; a_source = v.src;
    a_address = v.addr; a_mask = v.mask; a_data = v.data;
  endtask

  // Presents one request and pushes its expectation at the handshake edge.
  task automatic send(input vec_t v, input string tag);
    int guard = 0;
    @(negedge clk);
    drive(v);
    a_valid = 1'b1;
    while (!a_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!a_ready) begin
      check({tag, " a_ready timeout"}, 64'(a_ready), 64'd1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(v);
    #1 a_valid = 1'b0;
  endtask

  // Waits for the response, compares against the scoreboard, optionally holds d_ready low.
  task automatic recv(input int hold, input string tag);
    vec_t e;
    int   lat;
    @(negedge clk);
    lat = 1;
    while (!d_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " d_valid"}, 64'(d_valid), 64'd1);
    if (!d_valid) return;
    check({tag, " latency"}, 64'(lat), 64'd1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard entry"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, " d_opcode"},  64'(d_opcode),  64'(e.exp_op));
    check({tag, " d_data"},    d_data,         e.exp_data);
    check({tag, " d_source"},  64'(d_source),  64'(e.src));
    check({tag, " d_size"},    64'(d_size),    64'(e.size));
    check({tag, " d_denied"},  64'(d_denied),  64'(e.exp_denied));
    check({tag, " d_corrupt"}, 64'(d_corrupt), 64'(e.exp_corrupt));
    check({tag, " d_param"},   64'(d_param),   64'd0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({tag, " held d_valid"},  64'(d_valid),  64'd1);
      check({tag, " held a_ready"},  64'(a_ready),  64'd0);
      check({tag, " held d_data"},   d_data,        e.exp_data);
      check({tag, " held d_source"}, 64'(d_source), 64'(e.src));
      check({tag, " held d_opcode"}, 64'(d_opcode), 64'(e.exp_op));
    end
    d_ready = 1'b1;
    @(posedge clk);
    #1 d_ready = 1'b0;
    @(negedge clk);
    check({tag, " a_ready after resp"}, 64'(a_ready), 64'd1);
    check({tag, " d_valid after resp"}, 64'(d_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[13];
    vec_t v;
    logic [63:0] b2b_data[4];
    logic [AW-1:0] b2b_addr[4];
    int   sent, got, cyc, last_cyc;
    logic hs;

    vecs[0]  = mk(3'd0, 3'd3, 4'd2,  32'h0,   8'hFF, 64'hABCD_1234_5678_9ABC, 3'd0, 64'h0, 1'b0, 1'b0);
    vecs[1]  = mk(3'd4, 3'd3, 4'd1,  32'h0,   8'hFF, 64'h0, 3'd1, 64'hABCD_1234_5678_9ABC, 1'b0, 1'b0);
    vecs[2]  = mk(3'd1, 3'd3, 4'd3,  32'h0,   8'h0F, 64'h0000_0000_1111_2222, 3'd0, 64'h0, 1'b0, 1'b0);
    vecs[3]  = mk(3'd4, 3'd3, 4'd4,  32'h0,   8'hFF, 64'h0, 3'd1, 64'hABCD_1234_1111_2222, 1'b0, 1'b0);
    vecs[4]  = mk(3'd0, 3'd3, 4'd5,  32'h10,  8'hFF, 64'h0123_4567_89AB_CDEF, 3'd0, 64'h0, 1'b0, 1'b0);
    vecs[5]  = mk(3'd4, 3'd2, 4'd6,  32'h14,  8'h0F, 64'h0, 3'd1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    vecs[6]  = mk(3'd1, 3'd3, 4'd7,  32'h10,  8'hF0, 64'hFFFF_FFFF_0000_0000, 3'd0, 64'h0, 1'b0, 1'b0);
    vecs[7]  = mk(3'd4, 3'd3, 4'd8,  32'h10,  8'hFF, 64'h0, 3'd1, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1'b0);
    vecs[8]  = mk(3'd2, 3'd3, 4'd9,  32'h0,   8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'h0, DENY, 1'b0);
    vecs[9]  = mk(3'd4, 3'd3, 4'd10, 32'h0,   8'hFF, 64'h0, 3'd1, 64'hABCD_1234_1111_2222, 1'b0, 1'b0);
    vecs[10] = mk(3'd0, 3'd3, 4'd11, 32'h7F8, 8'hFF, 64'h5555_AAAA_5555_AAAA, 3'd0, 64'h0, 1'b0, 1'b0);
    vecs[11] = mk(3'd4, 3'd3, 4'd12, 32'h7F8, 8'hFF, 64'h0, 3'd1, 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b0);
    if (DENY)
      vecs[12] = mk(3'd4, 3'd3, 4'd13, 32'h800, 8'hFF, 64'h0, 3'd1, 64'h0, 1'b1, 1'b1);
    else
      vecs[12] = mk(3'd4, 3'd3, 4'd13, 32'h800, 8'hFF, 64'h0, 3'd1, 64'hABCD_1234_1111_2222, 1'b0, 1'b0);

    rst = 1'b1; a_valid = 1'b0; d_ready = 1'b0; a_param = 3'd0;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    check("reset a_ready",   64'(a_ready),   64'd0);
    check("reset d_valid",   64'(d_valid),   64'd0);
    check("reset d_opcode",  64'(d_opcode),  64'd0);
    check("reset d_param",   64'(d_param),   64'd0);
    check("reset d_size",    64'(d_size),    64'd0);
    check("reset d_source",  64'(d_source),  64'd0);
    check("reset d_denied",  64'(d_denied),  64'd0);
    check("reset d_data",    d_data,         64'd0);
    check("reset d_corrupt", 64'(d_corrupt), 64'd0);
    rst = 1'b0;
    #1 check("a_ready after reset", 64'(a_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      send(vecs[i], $sformatf("vec%0d", i));
      recv(0, $sformatf("vec%0d", i));
    end

    // Backpressure: response held for 5 cycles with d_ready low.
    v = mk(3'd4, 3'd3, 4'd14, 32'h10, 8'hFF, 64'h0, 3'd1, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1'b0);
    send(v, "stall");
    recv(5, "stall");

    // Reset while a write response is pending: write stays, response dropped.
    v = mk(3'd0, 3'd3, 4'd1, 32'h8, 8'hFF, 64'h0BAD_F00D_CAFE_BEEF, 3'd0, 64'h0, 1'b0, 1'b0);
    send(v, "rstmid");
    @(negedge clk);
    check("rstmid d_valid before rst", 64'(d_valid), 64'd1);
    void'(sb.pop_front());
    rst = 1'b1;
    @(negedge clk);
    check("rstmid d_valid after rst edge", 64'(d_valid), 64'd0);
    check("rstmid a_ready during rst",     64'(a_ready), 64'd0);
    rst = 1'b0;
    #1 check("rstmid a_ready after rst", 64'(a_ready), 64'd1);
    v = mk(3'd4, 3'd3, 4'd6, 32'h8, 8'hFF, 64'h0, 3'd1, 64'h0BAD_F00D_CAFE_BEEF, 1'b0, 1'b0);
    send(v, "rstmid get");
    recv(0, "rstmid get");

    // Back-to-back Gets, a_valid held high, d_ready high, sources 0..3.
    b2b_addr[0] = 32'h0;  b2b_data[0] = 64'hABCD_1234_1111_2222;
    b2b_addr[1] = 32'h8;  b2b_data[1] = 64'h0BAD_F00D_CAFE_BEEF;
    b2b_addr[2] = 32'h10; b2b_data[2] = 64'hFFFF_FFFF_89AB_CDEF;
    b2b_addr[3] = 32'h0;  b2b_data[3] = 64'hABCD_1234_1111_2222;
    sent = 0; got = 0; cyc = 0; last_cyc = 0;
    d_ready = 1'b1;
    @(negedge clk);
    v = mk(3'd4, 3'd3, 4'd0, b2b_addr[0], 8'hFF, 64'h0, 3'd1, b2b_data[0], 1'b0, 1'b0);
    drive(v);
    a_valid = 1'b1;
    while (got < 4 && cyc < 40) begin
      hs = a_valid && a_ready;
      if (d_valid) begin
        if (sb.size() == 0) check("b2b scoreboard entry", 64'd0, 64'd1);
        else begin
          v = sb.pop_front();
          check($sformatf("b2b%0d d_source", got), 64'(d_source), 64'(v.src));
          check($sformatf("b2b%0d d_data", got),   d_data,        v.exp_data);
          if (got > 0) check($sformatf("b2b%0d spacing", got), 64'(cyc - last_cyc), 64'd2);
        end
        last_cyc = cyc;
        got++;
      end
      @(posedge clk);
      if (hs) begin
        v = mk(3'd4, 3'd3, SRCW'(sent), b2b_addr[sent], 8'hFF, 64'h0, 3'd1, b2b_data[sent], 1'b0, 1'b0);
        sb.push_back(v);
        sent++;
        #1;
        if (sent < 4) begin
          v = mk(3'd4, 3'd3, SRCW'(sent), b2b_addr[sent], 8'hFF, 64'h0, 3'd1, b2b_data[sent], 1'b0, 1'b0);
          drive(v);
        end else a_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b response count", 64'(got), 64'd4);
    a_valid = 1'b0;
    d_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
